iccm_boot_loader: RTL and testbench

Framed program loader between the byte sources (UART programmer receiver / SPI slave byte mux) and the ICCM write port. It parses a sync/length/payload[/checksum] frame, packs bytes into 32-bit words, and issues word writes with a req/gnt handshake. It holds the core in reset until a frame completes cleanly. It replaces ad-hoc loading with length-bounded, error-checked loading.

---
 rtl/iccm_boot_pkg.sv | 19 +
 rtl/iccm_boot_loader_if.sv | 26 ++
 rtl/iccm_boot_word_packer.sv | 84 ++++++++
 rtl/iccm_boot_loader.sv | 162 ++++++++++++++++
 tb/tb_iccm_boot_loader.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iccm_boot_pkg.sv
// Shared types and constants for the ICCM boot loader.
// Frame: sync, 16-bit word count, payload words, optional checksum.
package iccm_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CKSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int LEN_W  = 16;
  localparam int BIDX_W = 2;

endpackage

// File: rtl/iccm_boot_loader_if.sv
// ICCM word-write port with req/gnt handshake.
// The master holds req, addr and wdata until the gnt cycle.
interface iccm_boot_loader_if #(
  parameter int AW = 12
);

  logic          req;
  logic          gnt;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;

  modport master (
    output req,
    output addr,
    output wdata,
    input  gnt
  );

  modport slave (
    input  req,
    input  addr,
    input  wdata,
    output gnt
  );

endinterface

// File: rtl/iccm_boot_word_packer.sv
// Packs little-endian bytes into words and drives the ICCM write port.
// A completed word waiting on gnt plus a further full word is an overflow.
module iccm_boot_word_packer
  import iccm_boot_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              feed_i,
  input  logic [7:0]        byte_i,
  output logic              word_o,
  output logic              ovf_o,
  output logic              pend_o,
  iccm_boot_loader_if.master mem
);

  logic [BIDX_W-1:0] idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       hold_q, hold_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              req_q, req_d;
  logic              last;

  assign last   = feed_i && (idx_q == BIDX_W'(3));
  assign ovf_o  = last && req_q && !mem.gnt;
  assign word_o = last && !ovf_o;
  assign pend_o = req_q;

  assign mem.req   = req_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = hold_q;

  always_comb begin
    idx_d  = idx_q;
    asm_d  = asm_q;
    hold_d = hold_q;
    addr_d = addr_q;
    req_d  = req_q;
    if (req_q && mem.gnt) begin
      req_d  = 1'b0;
      addr_d = addr_q + 1'b1;
    end
    if (feed_i) begin
      unique case (idx_q)
        2'd0: asm_d[7:0]   = byte_i;
        2'd1: asm_d[15:8]  = byte_i;
        2'd2: asm_d[23:16] = byte_i;
        default: begin
          if (!ovf_o) begin
            hold_d = {byte_i, asm_q};
            req_d  = 1'b1;
          end
        end
      endcase
      idx_d = idx_q + 1'b1;
    end
    if (clr_i) begin
      idx_d  = '0;
      asm_d  = '0;
      hold_d = '0;
      addr_d = '0;
      req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      asm_q  <= '0;
      hold_q <= '0;
      addr_q <= '0;
      req_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      asm_q  <= asm_d;
      hold_q <= hold_d;
      addr_q <= addr_d;
      req_q  <= req_d;
    end
  end

endmodule

// File: rtl/iccm_boot_loader.sv
// Framed ICCM program loader; releases core reset after a clean frame.
// ICCM_BOOT_CKSUM_EN adds a trailing mod-256 payload checksum byte.
module iccm_boot_loader
  import iccm_boot_pkg::*;
#(
  parameter int         AW             = 12,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  iccm_boot_loader_if.master mem,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned MAXW = 1 << AW;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [LEN_W:0]   len_ext, len_in;
  logic             feed, pk_word, pk_ovf, pk_pend, pk_clr;
  logic             tmo;
`ifdef ICCM_BOOT_CKSUM_EN
  logic [7:0]       cks_q, cks_d;
  logic             cks_ok_q, cks_ok_d;
`endif

  assign len_ext = {1'b0, len_q};
  assign len_in  = {1'b0, byte_i, len_q[7:0]};
  assign busy_o  = state_q inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CKSUM};
  assign done_o  = (state_q == ST_DONE);
  assign err_o   = (state_q == ST_ERR);
  assign core_rst_no = done_o;

  // Bytes past the last payload word are never fed to the packer
  assign feed = byte_valid_i && (state_q == ST_DATA) && (wcnt_q != len_ext);
  assign tmo  = busy_o && !byte_valid_i
             && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  iccm_boot_word_packer #(
    .AW(AW)
  ) u_packer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (pk_clr),
    .feed_i(feed),
    .byte_i(byte_i),
    .word_o(pk_word),
    .ovf_o (pk_ovf),
    .pend_o(pk_pend),
    .mem   (mem)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    pk_clr  = 1'b0;
    timer_d = (busy_o && !byte_valid_i) ? timer_q + 1'b1 : '0;
`ifdef ICCM_BOOT_CKSUM_EN
    cks_d    = cks_q;
    cks_ok_d = cks_ok_q;
    if (feed) cks_d = cks_q + byte_i;
`endif
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (byte_valid_i && byte_i == SYNC_BYTE) begin
          state_d = ST_LEN0;
          wcnt_d  = '0;
          pk_clr  = 1'b1;
`ifdef ICCM_BOOT_CKSUM_EN
          cks_d    = '0;
          cks_ok_d = 1'b0;
`endif
        end
      end
      ST_LEN0: begin
        if (byte_valid_i) begin
          len_d   = {len_q[15:8], byte_i};
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (byte_valid_i) begin
          len_d = {byte_i, len_q[7:0]};
          if (len_in > (LEN_W+1)'(MAXW)) state_d = ST_ERR;
`ifdef ICCM_BOOT_CKSUM_EN
          else if (len_in == '0) state_d = ST_CKSUM;
`else
          else if (len_in == '0) state_d = ST_DONE;
`endif
          else state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pk_ovf) begin
          state_d = ST_ERR;
        end else if (pk_word) begin
          wcnt_d = wcnt_q + 1'b1;
`ifdef ICCM_BOOT_CKSUM_EN
          if (wcnt_q + 1'b1 == len_ext) state_d = ST_CKSUM;
`endif
        end
`ifndef ICCM_BOOT_CKSUM_EN
        else if (wcnt_q == len_ext && (!pk_pend || mem.gnt)) begin
          state_d = ST_DONE;
        end
`endif
      end
`ifdef ICCM_BOOT_CKSUM_EN
      ST_CKSUM: begin
        if (byte_valid_i && !cks_ok_q) begin
          if (byte_i != cks_q) state_d = ST_ERR;
          else cks_ok_d = 1'b1;
        end
        if (state_d != ST_ERR && cks_ok_d && (!pk_pend || mem.gnt)) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (tmo && state_d != ST_DONE) state_d = ST_ERR;
    if (state_d == ST_ERR && state_q != ST_ERR) pk_clr = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      timer_q <= timer_d;
    end
  end

`ifdef ICCM_BOOT_CKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cks_q    <= '0;
      cks_ok_q <= 1'b0;
    end else begin
      cks_q    <= cks_d;
      cks_ok_q <= cks_ok_d;
    end
  end
`endif

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Directed bench for iccm_boot_loader: frame table plus corner sequences.
// Built with AW=4 and TIMEOUT_CYCLES=50; follows ICCM_BOOT_CKSUM_EN.
module tb_iccm_boot_loader;

  localparam int AW  = 4;
  localparam int TMO = 50;

  typedef struct {
    logic [15:0] len;
    int          nw;
    logic [31:0] base;
    bit          bad;
    bit          exp_done;
    bit          early_err;
    int          exp_wr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       bv = 1'b0;
  logic [7:0] bd = 8'h00;
  logic       core_rst_n, busy, done, err;

  int n_chk = 0;
  int n_fail = 0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  logic [7:0]    fq[$];
  vec_t          tbl[$];

  iccm_boot_loader_if #(.AW(AW)) mif ();

  iccm_boot_loader #(
    .AW(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .byte_valid_i(bv),
    .byte_i      (bd),
    .mem         (mif),
    .core_rst_no (core_rst_n),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_ni && mif.req && mif.gnt) begin
      wa.push_back(mif.addr);
      wd.push_back(mif.wdata);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] wgen(input logic [31:0] base, input int i);
    return base + 32'(i) * 32'h01020304;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    bv = 1'b0;
    repeat (3) @(negedge clk);
    wa.delete();
    wd.delete();
    rst_ni = 1'b1;
  endtask

  task automatic send_n(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bv = 1'b1;
      bd = fq.pop_front();
      @(negedge clk);
      bv = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_q(input int gap);
    send_n(fq.size(), gap);
  endtask

  task automatic build_frame(input logic [15:0] len, input int nw,
                             input logic [31:0] base, input bit bad);
    logic [7:0] s;
    logic [31:0] w;
    s = 8'h00;
    fq.push_back(8'hA5);
    fq.push_back(len[7:0]);
    fq.push_back(len[15:8]);
    for (int i = 0; i < nw; i++) begin
      w = wgen(base, i);
      for (int b = 0; b < 4; b++) begin
        fq.push_back(w[8*b +: 8]);
        s = s + w[8*b +: 8];
      end
    end
`ifdef ICCM_BOOT_CKSUM_EN
    fq.push_back(bad ? s + 8'd1 : s);
`endif
  endtask

  task automatic wait_end(input string nm);
    int k;
    k = 0;
    while (!done && !err && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!done && !err) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no done/err within 300 cycles", nm);
    end
  endtask

  initial begin
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    bit            stable;
    mif.gnt = 1'b1;

    tbl.push_back('{16'd1,     1,  32'h11223344, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{16'd3,     3,  32'hA0B0C0D0, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{16'd16,    16, 32'h00000100, 1'b0, 1'b1, 1'b0, 16});
    tbl.push_back('{16'd17,    0,  32'h0,        1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{16'd0,     0,  32'h0,        1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{16'h0100,  0,  32'h0,        1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{16'h8000,  0,  32'h0,        1'b0, 1'b0, 1'b1, 0});
`ifdef ICCM_BOOT_CKSUM_EN
    tbl.push_back('{16'd2,     2,  32'h55AA55AA, 1'b1, 1'b0, 1'b0, 2});
`endif

    @(negedge clk);
    chk("reset_outputs", 64'({mif.req, busy, done, err, core_rst_n}), 64'd0);

    foreach (tbl[v]) begin
      do_reset();
      build_frame(tbl[v].len, tbl[v].nw, tbl[v].base, tbl[v].bad);
      send_n(3, 0);
      if (tbl[v].early_err) begin
        chk($sformatf("v%0d_early_err", v), 64'({err, mif.req}), 64'b10);
      end
      send_q(1);
      wait_end($sformatf("v%0d_wait", v));
      chk($sformatf("v%0d_status", v),
          64'({done, err, core_rst_n, busy}),
          64'({tbl[v].exp_done, !tbl[v].exp_done, tbl[v].exp_done, 1'b0}));
      chk($sformatf("v%0d_nwrites", v), 64'(wa.size()), 64'(tbl[v].exp_wr));
      for (int i = 0; i < wa.size(); i++) begin
        chk($sformatf("v%0d_write%0d", v, i),
            {28'(wa[i]), wd[i]}, {28'(i), wgen(tbl[v].base, i)});
      end
    end

    // Nominal frame from the bring-up notes
    do_reset();
    fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef ICCM_BOOT_CKSUM_EN
    fq.push_back(8'h4B);
`endif
    send_q(1);
    wait_end("nominal_wait");
    chk("nominal_status", 64'({done, err, core_rst_n}), 64'b101);
    chk("nominal_nwrites", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      chk("nominal_w0", {28'(wa[0]), wd[0]}, {28'd0, 32'h00000013});
      chk("nominal_w1", {28'(wa[1]), wd[1]}, {28'd1, 32'hDEADBEEF});
    end

`ifdef ICCM_BOOT_CKSUM_EN
    do_reset();
    fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    send_q(1);
    wait_end("badcks_wait");
    chk("badcks_status", 64'({done, err, core_rst_n}), 64'b010);
    chk("badcks_nwrites", 64'(wa.size()), 64'd2);
    wa.delete();
    wd.delete();
    build_frame(16'd1, 1, 32'h00000077, 1'b0);
    send_q(1);
    wait_end("badcks_retry_wait");
    chk("badcks_retry_status", 64'({done, err, core_rst_n}), 64'b101);
    chk("badcks_retry_w0", {28'(wa[0]), wd[0]}, {28'd0, 32'h00000077});
`endif

    // Grant stall on word0 must not disturb the held write
    do_reset();
    mif.gnt = 1'b0;
    build_frame(16'd2, 2, 32'h01020304, 1'b0);
    send_n(6, 20);
    send_n(1, 0);
    a0 = mif.addr;
    d0 = mif.wdata;
    stable = mif.req;
    repeat (10) begin
      @(negedge clk);
      if (!mif.req || mif.addr !== a0 || mif.wdata !== d0) stable = 1'b0;
    end
    chk("stall_stable", 64'(stable), 64'd1);
    chk("stall_held_word", {28'(a0), d0}, {28'd0, wgen(32'h01020304, 0)});
    chk("stall_no_err", 64'(err), 64'd0);
    mif.gnt = 1'b1;
    send_q(20);
    wait_end("stall_wait");
    chk("stall_status", 64'({done, err}), 64'b10);
    chk("stall_nwrites", 64'(wa.size()), 64'd2);

    // Word1 completes while word0 is still ungranted
    do_reset();
    mif.gnt = 1'b0;
    build_frame(16'd2, 2, 32'h01020304, 1'b0);
    send_n(10, 2);
    chk("ovf_before", 64'({err, mif.req}), 64'b01);
    send_n(1, 0);
    chk("ovf_err", 64'({err, mif.req, busy}), 64'b100);
    fq.delete();
    mif.gnt = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovf_nwrites", 64'(wa.size()), 64'd0);

    // Inter-byte timeout
    do_reset();
    fq = '{8'hA5, 8'h01, 8'h00, 8'h13};
    send_n(4, 0);
    repeat (40) @(negedge clk);
    chk("tmo_pending", 64'({busy, err}), 64'b10);
    repeat (15) @(negedge clk);
    chk("tmo_fired", 64'({busy, err, core_rst_n}), 64'b010);
    build_frame(16'd0, 0, 32'h0, 1'b0);
    send_q(1);
    wait_end("tmo_retry_wait");
    chk("tmo_retry_status", 64'({done, err}), 64'b10);

    // Reset mid-frame with a pending write
    do_reset();
    mif.gnt = 1'b0;
    fq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_q(1);
    chk("midrst_pending", 64'({mif.req, busy}), 64'b11);
    rst_ni = 1'b0;
    #1;
    chk("midrst_outputs",
        64'({mif.req, busy, done, err, core_rst_n}), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    mif.gnt = 1'b1;
    fq = '{8'h00, 8'h13, 8'hFF, 8'h5A};
    send_q(1);
    chk("garbage_ignored", 64'({busy, done, err}), 64'd0);
    build_frame(16'd1, 1, 32'hCAFEF00D, 1'b0);
    send_q(1);
    wait_end("midrst_wait");
    chk("midrst_status", 64'({done, err, core_rst_n}), 64'b101);
    chk("midrst_nwrites", 64'(wa.size()), 64'd1);
    if (wa.size() == 1) begin
      chk("midrst_w0", {28'(wa[0]), wd[0]}, {28'd0, 32'hCAFEF00D});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
